// File: rtl/vga_output_controller.sv
// 640x480@60 VGA raster generator and output stage: requests pixels one cycle ahead,
// registers RGB together with hsync/vsync so colour and sync leave the block aligned.
module vga_output_controller #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] data_in,
   output logic        pixel_req,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        frame_start,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST   = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST   = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic       SYNC_IDLE  = ~SYNC_POL;

   // Stage 0: raster counters
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;
   logic       h_wrap;

   // Stage 0 decode
   logic       active_s0;
   logic       hsync_s0;
   logic       vsync_s0;

   // Stage 1: delayed flags while upstream drives data_in
   logic       active_s1_q;
   logic       hsync_s1_q;
   logic       vsync_s1_q;

   // Stage 2: output registers
   logic [11:0] rgb_q;
   logic        hsync_q;
   logic        vsync_q;

   assign h_wrap = (h_cnt_q == H_LAST);

   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         h_cnt_d = 10'd0;
         if (v_cnt_q == V_LAST) begin
            v_cnt_d = 10'd0;
         end else begin
            v_cnt_d = v_cnt_q + 10'd1;
         end
      end
   end

   always_comb begin
      active_s0 = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hsync_s0  = SYNC_IDLE;
      vsync_s0  = SYNC_IDLE;
      if ((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST)) begin
         hsync_s0 = SYNC_POL;
      end
      if ((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST)) begin
         vsync_s0 = SYNC_POL;
      end
   end

   // Counters park on the last raster position so the first edge after reset lands on (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= H_LAST;
         v_cnt_q <= V_LAST;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_s1_q <= 1'b0;
         hsync_s1_q  <= SYNC_IDLE;
         vsync_s1_q  <= SYNC_IDLE;
      end else begin
         active_s1_q <= active_s0;
         hsync_s1_q  <= hsync_s0;
         vsync_s1_q  <= vsync_s0;
      end
   end

   // Blanking forces black regardless of what upstream leaves on data_in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q   <= 12'h000;
         hsync_q <= SYNC_IDLE;
         vsync_q <= SYNC_IDLE;
      end else begin
         rgb_q   <= active_s1_q ? data_in : 12'h000;
         hsync_q <= hsync_s1_q;
         vsync_q <= vsync_s1_q;
      end
   end

   assign pixel_req   = active_s0;
   assign x           = h_cnt_q;
   assign y           = v_cnt_q;
   assign frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign red         = rgb_q[11:8];
   assign green       = rgb_q[7:4];
   assign blue        = rgb_q[3:0];

endmodule

// File: tb/tb_vga_output_controller.sv
// Bench for vga_output_controller: a default 640x480 instance and a shrunken raster instance
// (active-high sync) share clock, reset and pixel data; a scoreboard checks RGB and sync.
module tb_vga_output_controller;

   typedef struct packed {
      int ha; int hfp; int hs; int hbp;
      int va; int vfp; int vs; int vbp;
      bit pol;
   } cfg_t;

   localparam cfg_t CF = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, pol:1'b0};
   localparam cfg_t CS = '{ha:40, hfp:6, hs:10, hbp:8, va:12, vfp:3, vs:2, vbp:4, pol:1'b1};

   typedef struct {
      logic [11:0] rgbF;
      logic [11:0] rgbS;
      logic        hsF, vsF, hsS, vsS;
   } exp_t;

   logic        clk;
   logic        rstN;
   logic [11:0] dataIn;

   logic        fReq, fFs, fHs, fVs;
   logic [9:0]  fX, fY;
   logic [3:0]  fR, fG, fB;
   logic        sReq, sFs, sHs, sVs;
   logic [9:0]  sX, sY;
   logic [3:0]  sR, sG, sB;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   pushes = 0;
   int   pops = 0;
   int   c = -1;
   int   phase = 0;

   int   reqHigh = 0, hsLow = 0, hsFirst = -1;
   int   vsCnt = 0, vsFirst = -1, lastFs = -1, fsSeen = 0;

   vga_output_controller dutFull (
      .clk(clk), .rst_n(rstN), .data_in(dataIn),
      .pixel_req(fReq), .x(fX), .y(fY), .frame_start(fFs),
      .hsync(fHs), .vsync(fVs), .red(fR), .green(fG), .blue(fB)
   );

   vga_output_controller #(
      .H_ACTIVE(CS.ha), .H_FP(CS.hfp), .H_SYNC(CS.hs), .H_BP(CS.hbp),
      .V_ACTIVE(CS.va), .V_FP(CS.vfp), .V_SYNC(CS.vs), .V_BP(CS.vbp),
      .SYNC_POL(CS.pol)
   ) dutSmall (
      .clk(clk), .rst_n(rstN), .data_in(dataIn),
      .pixel_req(sReq), .x(sX), .y(sY), .frame_start(sFs),
      .hsync(sHs), .vsync(sVs), .red(sR), .green(sG), .blue(sB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, c, actual, expected);
      end
   endtask

   function automatic int hTotal(input cfg_t g);
      return g.ha + g.hfp + g.hs + g.hbp;
   endfunction

   function automatic int frameLen(input cfg_t g);
      return hTotal(g) * (g.va + g.vfp + g.vs + g.vbp);
   endfunction

   // Raster position of the cycle that is c clocks after the first post-reset edge.
   task automatic rasterAt(input cfg_t g, input int cyc, output int h, output int v);
      int f;
      f = ((cyc % frameLen(g)) + frameLen(g)) % frameLen(g);
      h = f % hTotal(g);
      v = f / hTotal(g);
   endtask

   function automatic logic syncLevel(input cfg_t g, input int pos, input int first, input int width);
      return (pos >= first && pos < first + width) ? g.pol : ~g.pol;
   endfunction

   task automatic checkRaster(input string tag, input cfg_t g, input logic req, input logic [9:0] xo,
                              input logic [9:0] yo, input logic fs);
      int h, v;
      rasterAt(g, c, h, v);
      check({tag, "_pixel_req"}, int'(req), int'(h < g.ha && v < g.va));
      check({tag, "_x"}, int'(xo), h);
      check({tag, "_y"}, int'(yo), v);
      check({tag, "_frame_start"}, int'(fs), int'(h == 0 && v == 0));
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, "_full_rgb"}, int'({fR, fG, fB}), 0);
      check({tag, "_full_hsync"}, int'(fHs), 1);
      check({tag, "_full_vsync"}, int'(fVs), 1);
      check({tag, "_full_req"}, int'(fReq), 0);
      check({tag, "_full_xy"}, int'({fX, fY}), (799 << 10) | 524);
      check({tag, "_full_fs"}, int'(fFs), 0);
      check({tag, "_small_rgb"}, int'({sR, sG, sB}), 0);
      check({tag, "_small_hsync"}, int'(sHs), 0);
      check({tag, "_small_vsync"}, int'(sVs), 0);
      check({tag, "_small_req"}, int'(sReq), 0);
   endtask

   // Drive one cycle's data, check the raster, and queue the output due next cycle.
   task automatic applyStimulus();
      int   hF, vF, hS, vS;
      exp_t e;
      dataIn = 12'($urandom_range(0, 4095));
      if (phase == 0 && c == 1) dataIn = 12'hABC;
      if (phase == 0 && c == 2) dataIn = 12'h123;
      if (phase == 0 && c >= 630 && c < 900) dataIn = 12'hFFF;

      checkRaster("full", CF, fReq, fX, fY, fFs);
      checkRaster("small", CS, sReq, sX, sY, sFs);

      rasterAt(CF, c - 1, hF, vF);
      rasterAt(CS, c - 1, hS, vS);
      e.rgbF = (hF < CF.ha && vF < CF.va) ? dataIn : 12'h000;
      e.rgbS = (hS < CS.ha && vS < CS.va) ? dataIn : 12'h000;
      e.hsF  = syncLevel(CF, hF, CF.ha + CF.hfp, CF.hs);
      e.vsF  = syncLevel(CF, vF, CF.va + CF.vfp, CF.vs);
      e.hsS  = syncLevel(CS, hS, CS.ha + CS.hfp, CS.hs);
      e.vsS  = syncLevel(CS, vS, CS.va + CS.vfp, CS.vs);
      q.push_back(e);
      pushes++;

      if (phase == 0) begin
         if (c == 2) check("pixel_abc", int'({fR, fG, fB}), 12'hABC);
         if (c == 3) check("pixel_123", int'({fR, fG, fB}), 12'h123);
         if (c == 642) check("blank_after_x640", int'({fR, fG, fB}), 0);
         if (c < 800 && fReq) reqHigh++;
         if (c < 1000 && fHs == 1'b0) begin
            hsLow++;
            if (hsFirst < 0) hsFirst = c;
         end
         if (c < frameLen(CS) && sVs == CS.pol) begin
            vsCnt++;
            if (vsFirst < 0) vsFirst = c;
         end
         if (sFs) begin
            if (lastFs >= 0) check("frame_period_small", c - lastFs, frameLen(CS));
            lastFs = c;
            fsSeen++;
         end
      end
   endtask

   task automatic releaseReset();
      exp_t e;
      @(negedge clk);
      rstN = 1'b1;
      c = -1;
      e.rgbF = 12'h000; e.rgbS = 12'h000;
      e.hsF = ~CF.pol; e.vsF = ~CF.pol; e.hsS = ~CS.pol; e.vsS = ~CS.pol;
      q.push_back(e);
      pushes++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c++;
         applyStimulus();
      end
   endtask

   // Monitor: each cycle the DUTs present a registered output, compare it with the queued one.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         pops++;
         check("full_rgb", int'({fR, fG, fB}), int'(e.rgbF));
         check("full_hsync", int'(fHs), int'(e.hsF));
         check("full_vsync", int'(fVs), int'(e.vsF));
         check("small_rgb", int'({sR, sG, sB}), int'(e.rgbS));
         check("small_hsync", int'(sHs), int'(e.hsS));
         check("small_vsync", int'(sVs), int'(e.vsS));
      end
   end

   task automatic checkOutput();
      check("line0_req_high", reqHigh, CF.ha);
      check("line0_hsync_low", hsLow, CF.hs);
      check("line0_hsync_start", hsFirst, CF.ha + CF.hfp + 2);
      check("small_vsync_width", vsCnt, CF.vs * hTotal(CS));
      check("small_vsync_start", vsFirst, (CS.va + CS.vfp) * hTotal(CS) + 2);
      check("small_frames_seen", fsSeen, 4);
   endtask

   initial begin
      rstN   = 1'b0;
      dataIn = 12'h000;
      repeat (5) @(posedge clk);
      #2;
      checkResetValues("reset");
      #1;
      releaseReset();
      runCycles(3 * frameLen(CS) + 7 * hTotal(CS) + 20);
      checkOutput();

      phase = 1;
      @(posedge clk);
      #3;
      rstN = 1'b0;
      #1;
      checkResetValues("midframe_reset");
      repeat (3) @(posedge clk);
      #2;
      checkResetValues("midframe_hold");
      releaseReset();
      runCycles(frameLen(CS) + 100);

      @(posedge clk);
      #2;
      check("scoreboard_drain", pops, pushes);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
